// File: rtl/sdram_pattern_tester_pkg.sv
// Shared types and helpers for the SDRAM pattern tester.
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_READ
  } state_e;

  typedef enum logic [1:0] {
    MODE_INC  = 2'd0,
    MODE_WALK = 2'd1,
    MODE_ADDR = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  // Word address of word 'index' within burst 'region'; callers truncate to ADDR_W.
  function automatic logic [63:0] word_addr(input logic [63:0] base,
                                            input logic [31:0] region,
                                            input logic [31:0] burst_len,
                                            input logic [31:0] index);
    return base + 64'(region) * 64'(burst_len) + 64'(index);
  endfunction

endpackage

// File: rtl/sdram_pattern_tester_if.sv
// Burst request/ack bus between the pattern tester (master) and the SDRAM controller (slave).
interface sdram_pattern_tester_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 24
);
  logic              sdram_init_done;
  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [ADDR_W-1:0] sys_wraddr;
  logic [ADDR_W-1:0] sys_rdaddr;
  logic [9:0]        sdwr_byte;
  logic [9:0]        sdrd_byte;
  logic [DATA_W-1:0] sys_data_in;
  logic [DATA_W-1:0] sys_data_out;

  modport master (
    input  sdram_init_done, sdram_wr_ack, sdram_rd_ack, sys_data_out,
    output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
           sdwr_byte, sdrd_byte, sys_data_in
  );

  modport slave (
    output sdram_init_done, sdram_wr_ack, sdram_rd_ack, sys_data_out,
    input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr,
           sdwr_byte, sdrd_byte, sys_data_in
  );
endinterface

// File: rtl/sdram_pattern_gen.sv
// Combinational test-pattern generator: (mode, word index, region, seed) -> data word.
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BURST_LEN = 512,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned IDX_W     = 9,
  parameter int unsigned REG_W     = 2
) (
  input  mode_e             mode,
  input  logic [IDX_W-1:0]  index,
  input  logic [REG_W-1:0]  region,
  input  logic [7:0]        seed,
  output logic [DATA_W-1:0] word
);

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] sum;

  assign waddr = ADDR_W'(word_addr(64'(BASE_ADDR), 32'(region), 32'(BURST_LEN), 32'(index)));
  assign sum   = DATA_W'(seed) + DATA_W'(index);

  // Pattern select
  always_comb begin
    word = '0;
    case (mode)
      MODE_INC:  word = sum;
      MODE_WALK: word = DATA_W'(1) << (32'(index) % DATA_W);
      MODE_ADDR: word = DATA_W'(waddr);
      MODE_INV:  word = ~sum;
      default:   word = '0;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern tester: writes a patterned burst, waits, reads it back and verifies.
// Optional macro SDRAM_TESTER_ERRLOG_EN adds err_cnt and first_fail_addr outputs.
module sdram_pattern_tester
  import sdram_tester_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned BURST_LEN  = 512,
  parameter int unsigned REGION_CNT = 4,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned INTERVAL   = 99_999_999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  sdram_pattern_tester_if.master sd,
  output logic                  busy,
  output logic                  error,
  output logic [15:0]           pass_cnt
`ifdef SDRAM_TESTER_ERRLOG_EN
  ,
  output logic [15:0]           err_cnt,
  output logic [ADDR_W-1:0]     first_fail_addr
`endif
);

  localparam int unsigned IDX_W = $clog2(BURST_LEN);
  localparam int unsigned REG_W = (REGION_CNT > 1) ? $clog2(REGION_CNT) : 1;

  state_e            state, state_nx;
  mode_e             mode_q;
  logic [IDX_W-1:0]  idx;
  logic [REG_W-1:0]  region;
  logic [31:0]       ivl_cnt;
  logic [DATA_W-1:0] exp_word;
  logic              ivl_done, last_word, mismatch;

  assign ivl_done  = (ivl_cnt == INTERVAL);
  assign last_word = (idx == IDX_W'(BURST_LEN - 1));
  assign mismatch  = (state == ST_READ) && sd.sdram_rd_ack && (sd.sys_data_out != exp_word);

  assign sd.sys_wraddr = ADDR_W'(word_addr(64'(BASE_ADDR), 32'(region), 32'(BURST_LEN), 32'd0));
  assign sd.sys_rdaddr = sd.sys_wraddr;
  assign sd.sdwr_byte  = 10'(BURST_LEN);
  assign sd.sdrd_byte  = 10'(BURST_LEN);

  sdram_pattern_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W), .REG_W(REG_W)
  ) u_gen_wr (
    .mode(mode_q), .index(idx), .region(region), .seed(pass_cnt[7:0]), .word(sd.sys_data_in)
  );

  sdram_pattern_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W), .REG_W(REG_W)
  ) u_gen_rd (
    .mode(mode_q), .index(idx), .region(region), .seed(pass_cnt[7:0]), .word(exp_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nx;
  end

  // Next-state and request/busy decode
  always_comb begin
    state_nx        = state;
    sd.sdram_wr_req = 1'b0;
    sd.sdram_rd_req = 1'b0;
    busy            = 1'b0;
    case (state)
      ST_INIT:  if (sd.sdram_init_done) state_nx = ST_IDLE;
      ST_IDLE:  if (ivl_done && enable) state_nx = ST_WRITE;
      ST_WRITE: begin
        sd.sdram_wr_req = 1'b1;
        busy            = 1'b1;
        if (sd.sdram_wr_ack && last_word) state_nx = ST_GAP;
      end
      ST_GAP: begin
        busy = 1'b1;
        if (ivl_done) state_nx = ST_READ;
      end
      ST_READ: begin
        sd.sdram_rd_req = 1'b1;
        busy            = 1'b1;
        if (sd.sdram_rd_ack && last_word) state_nx = ST_IDLE;
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // Word index, interval counter, mode latch, pass/region bookkeeping and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      ivl_cnt  <= '0;
      mode_q   <= MODE_INC;
      region   <= '0;
      pass_cnt <= '0;
      error    <= 1'b0;
    end else begin
      // Index and interval counter restart on every state entry; IDLE holds at terminal count.
      if (state_nx != state) begin
        idx     <= '0;
        ivl_cnt <= '0;
      end else begin
        if ((state == ST_WRITE && sd.sdram_wr_ack) || (state == ST_READ && sd.sdram_rd_ack))
          idx <= idx + 1'b1;
        if ((state == ST_IDLE || state == ST_GAP) && !ivl_done)
          ivl_cnt <= ivl_cnt + 32'd1;
      end
      if (state == ST_IDLE && state_nx == ST_WRITE)
        mode_q <= mode_e'(mode);
      if (mismatch)
        error <= 1'b1;
      if (state == ST_READ && sd.sdram_rd_ack && last_word) begin
        pass_cnt <= pass_cnt + 16'd1;
        if (region == REG_W'(REGION_CNT - 1)) region <= '0;
        else                                  region <= region + 1'b1;
      end
    end
  end

`ifdef SDRAM_TESTER_ERRLOG_EN
  // Mismatch counter (saturating) and address of the first failing word
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt         <= '0;
      first_fail_addr <= '0;
    end else if (mismatch) begin
      if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      if (!error)
        first_fail_addr <= ADDR_W'(word_addr(64'(BASE_ADDR), 32'(region), 32'(BURST_LEN), 32'(idx)));
    end
  end
`endif

endmodule

// File: doc/sdram_pattern_tester.md
SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 Parameter DATA_W, default 16, SDRAM word width.
REQ-002 Parameter ADDR_W, default 24, word address width.
REQ-003 Parameter BURST_LEN, default 512, words per burst; power of 2, range 2..512.
REQ-004 Parameter REGION_CNT, default 4, bursts per pass; power of 2.
REQ-005 Parameter BASE_ADDR, default 0, first word address of region 0.
REQ-006 Parameter INTERVAL, default 99_999_999, idle cycles between operations.
REQ-007 Port clk  in  1  single clock, the 100 MHz SDRAM controller clock.
REQ-008 Port rst  in  1  synchronous active-high reset.
REQ-009 Port enable  in  1  run tests while high.
REQ-010 Port mode  in  2  pattern select: 0 increment, 1 walking-one, 2 address, 3 inverted increment.
REQ-011 Port sdram_init_done  in  1  controller initialisation complete.
REQ-012 Ports sdram_wr_req/sdram_rd_req  out  1  burst requests; sdram_wr_ack/sdram_rd_ack  in  1  per-word acks.
REQ-013 Ports sys_wraddr/sys_rdaddr  out  ADDR_W; sdwr_byte/sdrd_byte  out  10, both equal to BURST_LEN.
REQ-014 Port sys_data_in  out  DATA_W  write data; sys_data_out  in  DATA_W  read data.
REQ-015 Ports busy out 1; error out 1, sticky; pass_cnt out 16, completed read-verify bursts.

Function
REQ-016 States: INIT, IDLE, WRITE, GAP, READ; INIT->IDLE when sdram_init_done=1.
REQ-017 IDLE and GAP count INTERVAL+1 cycles; IDLE->WRITE on expiry only if enable=1, else the counter holds at terminal count; GAP->READ on expiry regardless of enable.
REQ-018 WRITE asserts sdram_wr_req; READ asserts sdram_rd_req; neither is asserted in any other state.
REQ-019 Word index i resets to 0 on state entry and increments on each cycle the matching ack is high.
REQ-020 sys_data_in is a combinational function of (mode, i, region, seed); seed = pass_cnt[7:0]; it is valid in the same cycle as wr_ack.
REQ-021 Patterns: increment = seed+i; walking-one = 1<<(i mod DATA_W); address = low DATA_W bits of word address; inverted increment = ~(seed+i).
REQ-022 Mode is latched on entry to WRITE and used for both WRITE and the following READ; mid-pass changes apply only to the next burst.
REQ-023 Word address = BASE_ADDR + region*BURST_LEN + 0; sys_wraddr equals sys_rdaddr for the same region.
REQ-024 WRITE->GAP on the ack of word BURST_LEN-1; READ->IDLE on the rd_ack of word BURST_LEN-1.
REQ-025 On each rd_ack, compare sys_data_out to the expected pattern for index i; any mismatch sets error.
REQ-026 At READ exit: pass_cnt increments and wraps 0xFFFF->0; region increments and wraps REGION_CNT-1->0.
REQ-027 busy = 1 in WRITE, GAP and READ.
REQ-028 Deasserting enable mid-burst does not abort; the write/read pair completes.

Reset
REQ-029 rst=1 at a clock edge forces INIT, i=0, region=0, pass_cnt=0, error=0, interval counter=0, and both requests=0; it takes effect mid-burst.

Configuration
REQ-030 Macro SDRAM_TESTER_ERRLOG_EN: when defined, adds outputs err_cnt (16, saturating at 0xFFFF) and first_fail_addr (ADDR_W), captured on the first mismatch after reset and held. When undefined, these ports and their logic are absent and all other behaviour is unchanged.

Structure
REQ-031 Package sdram_tester_pkg holds the state encoding, the mode constants and the per-word address computation function.
REQ-032 Sub-module sdram_pattern_gen is purely combinational (mode, index, region, seed -> word) and is instantiated twice: once for write data, once for expected read data.

Verification (BURST_LEN=8, REGION_CNT=2, INTERVAL=4, BASE_ADDR=0, behavioural SDRAM model)
REQ-033 Init done, enable=1, mode=0: 8 writes of data 0..7 at address 0, then 5 GAP cycles, read back; error=0, pass_cnt=1, next burst at address 8.
REQ-034 Mode=1: write data sequence 0x0001, 0x0002, ... 0x0080; read back matches; error=0.
REQ-035 Model corrupts read word 3 by 0x0100: error=1 persists; with the macro defined, err_cnt=1 and first_fail_addr=3.
REQ-036 Two passes complete: region returns to 0 with address 0 and seed=2; the third burst's data starts at 0x0002.
REQ-037 rst=1 during word 4 of READ: requests drop the next cycle; after release the block waits in INIT until sdram_init_done=1, then restarts at region 0.
REQ-038 enable=0 asserted during WRITE: the block finishes WRITE, GAP and READ, then stays in IDLE with busy=0 until enable=1.
